// File: rtl/fip_pkg.sv
// fip_pkg: shared Q16.16 fixed-point types, limits and divider FSM states.
package fip_pkg;
  localparam int FIP_INT_BITS = 16;
  localparam int FIP_FRAC_BITS = 16;
  localparam logic [31:0] FIP_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] FIP_MIN = 32'h8000_0000;
  typedef logic signed [31:0] fip_t;
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} div_state_t;
endpackage

// File: rtl/fip_div_step.sv
// fip_div_step: one combinational restoring-division step on a 33-bit remainder.
module fip_div_step (
  input  logic [32:0] rem_in,
  input  logic [31:0] den,
  input  logic        bit_in,
  output logic [32:0] rem_out,
  output logic        qbit
);
  logic [32:0] sh;
  assign sh = {rem_in[31:0], bit_in};
  // rem_in[32] set means the shifted value exceeds 2^33, so it always covers den
  assign qbit = rem_in[32] | (sh >= {1'b0, den});
  assign rem_out = qbit ? sh - {1'b0, den} : sh;
endmodule

// File: rtl/fip_32_div_iter.sv
// fip_32_div_iter: multi-cycle saturating signed Q16.16 divider, BPC quotient bits per cycle.
module fip_32_div_iter
  import fip_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        overflow,
  output logic        div_by_zero
);
  localparam int ITER = 48 / BPC;
  localparam logic [5:0] LAST = 6'(ITER - 1);
  div_state_t state, state_n;
  logic        neg;
  logic [47:0] num;
  logic [31:0] den;
  logic [32:0] rem;
  logic [5:0]  cnt;
  logic [32:0] rc [0:BPC];
  logic [BPC-1:0] qb;
  logic [31:0] a_dd, a_ds, q_fix;
  logic        sat_pos, sat_neg;
  assign a_dd = dividend[31] ? 32'(-dividend) : dividend;
  assign a_ds = divisor[31] ? 32'(-divisor) : divisor;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign rc[0] = rem;
  // num doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom
  for (genvar g = 0; g < BPC; g++) begin : g_step
    fip_div_step u_step (
      .rem_in (rc[g]),
      .den    (den),
      .bit_in (num[47-g]),
      .rem_out(rc[g+1]),
      .qbit   (qb[BPC-1-g])
    );
  end
  assign sat_pos = !neg && num > 48'h0000_7FFF_FFFF;
  assign sat_neg = neg && num > 48'h0000_8000_0000;
  assign q_fix = sat_pos ? FIP_MAX : sat_neg ? FIP_MIN : neg ? 32'(-num[31:0]) : num[31:0];
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = (divisor == 32'd0) ? DONE : CALC;
      CALC: if (cnt == LAST) state_n = SIGN;
      SIGN: state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      neg         <= 1'b0;
      num         <= '0;
      den         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          if (divisor == 32'd0) begin
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            neg <= dividend[31] ^ divisor[31];
            num <= {a_dd, {FIP_FRAC_BITS{1'b0}}};
            den <= a_ds;
            rem <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          rem <= rc[BPC];
          num <= {num[47-BPC:0], qb};
          cnt <= cnt + 6'd1;
        end
        SIGN: begin
          quotient    <= q_fix;
          overflow    <= sat_pos | sat_neg;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
